// File: rtl/msg_pkg.sv
// Shared widths and helpers for the message path stages.
package msg_pkg;

    localparam int MSG_DATA_W = 256;
    localparam int MSG_MASK_W = 32;
    localparam int MSG_LEN_W  = 6;
    localparam int CNT_W      = 16;

    // Number of set bits in a byte mask, i.e. the message byte length.
    function automatic logic [MSG_LEN_W-1:0] msg_popcount(input logic [MSG_MASK_W-1:0] mask);
        logic [MSG_LEN_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < MSG_MASK_W; i++) begin
            cnt = cnt + MSG_LEN_W'(mask[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/msg_len_calc.sv
// Combinational byte-length calculator: popcount of a byte mask.
module msg_len_calc
    import msg_pkg::*;
#(
    parameter int MASK_W = MSG_MASK_W,
    parameter int LEN_W  = MSG_LEN_W
) (
    input  logic [MASK_W-1:0] mask,
    output logic [LEN_W-1:0]  length
);

    // Count the valid-byte bits of the mask.
    always_comb begin
        length = '0;
        for (int i = 0; i < MASK_W; i++) begin
            length = length + LEN_W'(mask[i]);
        end
    end

endmodule

// File: rtl/msg_fifo_buffer.sv
// Show-ahead message FIFO behind the message extractor. Never stalls its
// input: a write that finds the FIFO full is dropped and flagged with a
// one-cycle overflow pulse.
// Handshake: the head entry transfers on any edge where out_valid and
// out_ready are both high; out_valid never depends on out_ready.
// Build option: define MSG_FIFO_STATS_EN to implement msg_count/drop_count;
// otherwise both read 0 and their registers are absent.
module msg_fifo_buffer
    import msg_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int DATA_W = MSG_DATA_W,
    parameter int MASK_W = MSG_MASK_W,
    parameter int LEN_W  = MSG_LEN_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [MASK_W-1:0] in_bytemask,
    input  logic              flush,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [MASK_W-1:0] out_bytemask,
    output logic [LEN_W-1:0]  out_length,
    output logic [ADDR_W:0]   fill_level,
    output logic              overflow,
    output logic [CNT_W-1:0]  msg_count,
    output logic [CNT_W-1:0]  drop_count
);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
    logic              overflow_q, overflow_d;

    logic [DATA_W-1:0] data_mem_q [DEPTH];
    logic [MASK_W-1:0] mask_mem_q [DEPTH];
    logic [LEN_W-1:0]  len_mem_q  [DEPTH];

    logic [LEN_W-1:0]  in_length;
    logic              empty, full, pop, wr_qual, wr_accept, drop;

    msg_len_calc #(
        .MASK_W (MASK_W),
        .LEN_W  (LEN_W)
    ) u_len_calc (
        .mask   (in_bytemask),
        .length (in_length)
    );

    // Occupancy, handshake and write acceptance decisions.
    always_comb begin
        empty     = (wr_ptr_q == rd_ptr_q);
        full      = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
                    (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);
        pop       = !empty && out_ready;
        wr_qual   = in_valid && (in_bytemask != '0) && !flush;
        // A pop frees the head slot on the same edge, so a full FIFO can still take a write.
        wr_accept = wr_qual && (!full || pop);
        drop      = wr_qual && !wr_accept;
    end

    // Next-state for pointers and the overflow pulse; flush wins over everything.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = drop;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_accept) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)       rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // Pointer and overflow registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    // Entry storage; contents are left unreset since pointers gate visibility.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            data_mem_q[wr_ptr_q[ADDR_W-1:0]] <= in_data;
            mask_mem_q[wr_ptr_q[ADDR_W-1:0]] <= in_bytemask;
            len_mem_q[wr_ptr_q[ADDR_W-1:0]]  <= in_length;
        end
    end

    // Show-ahead head presentation, forced to zero while empty.
    always_comb begin
        out_valid    = !empty;
        out_data     = '0;
        out_bytemask = '0;
        out_length   = '0;
        if (!empty) begin
            out_data     = data_mem_q[rd_ptr_q[ADDR_W-1:0]];
            out_bytemask = mask_mem_q[rd_ptr_q[ADDR_W-1:0]];
            out_length   = len_mem_q[rd_ptr_q[ADDR_W-1:0]];
        end
    end

    assign fill_level = wr_ptr_q - rd_ptr_q;
    assign overflow   = overflow_q;

`ifdef MSG_FIFO_STATS_EN
    logic [CNT_W-1:0] msg_count_q, msg_count_d;
    logic [CNT_W-1:0] drop_count_q, drop_count_d;

    // Saturating accepted/dropped message counters; flush leaves them alone.
    always_comb begin
        msg_count_d  = msg_count_q;
        drop_count_d = drop_count_q;
        if (wr_accept && (msg_count_q != '1))  msg_count_d  = msg_count_q + 1'b1;
        if (drop && (drop_count_q != '1))      drop_count_d = drop_count_q + 1'b1;
    end

    // Counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            msg_count_q  <= '0;
            drop_count_q <= '0;
        end else begin
            msg_count_q  <= msg_count_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign msg_count  = msg_count_q;
    assign drop_count = drop_count_q;
`else
    assign msg_count  = '0;
    assign drop_count = '0;
`endif

endmodule

// File: tb/tb_msg_fifo_buffer.sv
// Bench for msg_fifo_buffer: scoreboard of {data, mask} entries.
module tb_msg_fifo_buffer;

    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;
    localparam int DATA_W = 256;
    localparam int MASK_W = 32;
    localparam int LEN_W  = 6;
    localparam int W      = DATA_W + MASK_W;

    logic              clk;
    logic              reset_n;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic [MASK_W-1:0] in_bytemask;
    logic              flush;
    logic              out_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [MASK_W-1:0] out_bytemask;
    logic [LEN_W-1:0]  out_length;
    logic [ADDR_W:0]   fill_level;
    logic              overflow;
    logic [15:0]       msg_count;
    logic [15:0]       drop_count;

    logic [W-1:0] exp_q[$];
    int           checks;
    int           errors;
    int           exp_msg;
    int           exp_drop;

    msg_fifo_buffer #(
        .DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_bytemask  (in_bytemask),
        .flush        (flush),
        .out_ready    (out_ready),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_bytemask (out_bytemask),
        .out_length   (out_length),
        .fill_level   (fill_level),
        .overflow     (overflow),
        .msg_count    (msg_count),
        .drop_count   (drop_count)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int stat_exp(input int v);
`ifdef MSG_FIFO_STATS_EN
        return (v > 65535) ? 65535 : v;
`else
        return 0 * v;
`endif
    endfunction

    function automatic logic [MASK_W-1:0] mask_of_len(input int len);
        logic [MASK_W:0] t;
        t = (33'h1 << len) - 33'h1;
        return t[MASK_W-1:0];
    endfunction

    function automatic logic [DATA_W-1:0] rand_data();
        logic [DATA_W-1:0] d;
        for (int i = 0; i < DATA_W / 32; i++) d[i*32 +: 32] = $urandom();
        return d;
    endfunction

    // One clock cycle: drive inputs, check the head on a pop, predict, then check state.
    task automatic cycle(input logic v, input logic [DATA_W-1:0] d, input logic [MASK_W-1:0] m,
                         input logic rdy, input logic fl);
        logic         qual, pop, accept, drop;
        logic [W-1:0] head;
        in_valid    = v;
        in_data     = d;
        in_bytemask = m;
        out_ready   = rdy;
        flush       = fl;
        #1;
        pop = (exp_q.size() != 0) && rdy;
        if (pop && !fl) begin
            head = exp_q[0];
            checks++;
            if ({out_data, out_bytemask} !== head ||
                out_length !== LEN_W'($countones(head[MASK_W-1:0]))) begin
                errors++;
                $display("FAIL head: got data=%h mask=%h len=%0d, expected data=%h mask=%h len=%0d",
                         out_data, out_bytemask, out_length, head[W-1:MASK_W], head[MASK_W-1:0],
                         $countones(head[MASK_W-1:0]));
            end
        end
        qual   = v && (m != '0) && !fl;
        accept = qual && ((exp_q.size() < DEPTH) || pop);
        drop   = qual && !accept;
        @(posedge clk);
        if (fl) begin
            exp_q.delete();
        end else begin
            if (pop)    void'(exp_q.pop_front());
            if (accept) exp_q.push_back({d, m});
        end
        if (accept) exp_msg++;
        if (drop)   exp_drop++;
        #1;
        checks++;
        if (overflow !== drop || fill_level !== (ADDR_W+1)'(exp_q.size()) ||
            out_valid !== (exp_q.size() != 0)) begin
            errors++;
            $display("FAIL state: got ovf=%0b fill=%0d valid=%0b, expected ovf=%0b fill=%0d valid=%0b",
                     overflow, fill_level, out_valid, drop, exp_q.size(), exp_q.size() != 0);
        end
        checks++;
        if (msg_count !== 16'(stat_exp(exp_msg)) || drop_count !== 16'(stat_exp(exp_drop))) begin
            errors++;
            $display("FAIL counters: got msg=%0d drop=%0d, expected msg=%0d drop=%0d",
                     msg_count, drop_count, stat_exp(exp_msg), stat_exp(exp_drop));
        end
        if (exp_q.size() == 0) begin
            checks++;
            if (out_data !== '0 || out_bytemask !== '0 || out_length !== '0) begin
                errors++;
                $display("FAIL empty_head: got data=%h mask=%h len=%0d, expected all 0",
                         out_data, out_bytemask, out_length);
            end
        end
    endtask

    task automatic push(input logic [DATA_W-1:0] d, input logic [MASK_W-1:0] m);
        cycle(1'b1, d, m, 1'b0, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 2 && exp_q.size() != 0; i++) begin
            cycle(1'b0, '0, '0, 1'b1, 1'b0);
        end
        checks++;
        if (exp_q.size() != 0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain: got valid=%0b, expected 0 (model holds %0d)", out_valid, exp_q.size());
        end
    endtask

    // Asynchronous reset: outputs must clear without waiting for an edge.
    task automatic apply_reset();
        reset_n = 1'b0;
        #1;
        exp_q.delete();
        exp_msg  = 0;
        exp_drop = 0;
        checks++;
        if (out_valid !== 1'b0 || fill_level !== '0 || overflow !== 1'b0 || msg_count !== '0 ||
            drop_count !== '0 || out_data !== '0 || out_bytemask !== '0 || out_length !== '0) begin
            errors++;
            $display("FAIL reset: got valid=%0b fill=%0d ovf=%0b msg=%0d drop=%0d len=%0d, expected all 0",
                     out_valid, fill_level, overflow, msg_count, drop_count, out_length);
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
    endtask

    task automatic test_single();
        logic [DATA_W-1:0] d;
        d = '0;
        d[7:0] = 8'hA5;
        push(d, 32'h0000_003F);
        checks++;
        if (out_length !== 6'd6 || fill_level !== 4'd1) begin
            errors++;
            $display("FAIL single_len: got len=%0d fill=%0d, expected len=6 fill=1", out_length, fill_level);
        end
        cycle(1'b0, '0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < DEPTH; i++) push(rand_data(), mask_of_len($urandom_range(1, 32)));
        push(rand_data(), mask_of_len(4));
        checks++;
        if (overflow !== 1'b1 || fill_level !== 4'd8) begin
            errors++;
            $display("FAIL overflow_pulse: got ovf=%0b fill=%0d, expected ovf=1 fill=8", overflow, fill_level);
        end
        cycle(1'b0, '0, '0, 1'b0, 1'b0);
        drain();
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < DEPTH; i++) push(rand_data(), mask_of_len(i + 1));
        cycle(1'b1, rand_data(), mask_of_len(17), 1'b1, 1'b0);
        checks++;
        if (overflow !== 1'b0 || fill_level !== 4'd8) begin
            errors++;
            $display("FAIL full_push_pop: got ovf=%0b fill=%0d, expected ovf=0 fill=8", overflow, fill_level);
        end
        drain();
    endtask

    task automatic test_zero_mask();
        push(rand_data(), '0);
        push(rand_data(), 32'hFFFF_FFFF);
        checks++;
        if (out_length !== 6'd32) begin
            errors++;
            $display("FAIL full_mask_len: got len=%0d, expected 32", out_length);
        end
        drain();
    endtask

    task automatic test_flush();
        int msg_before;
        for (int i = 0; i < 5; i++) push(rand_data(), mask_of_len($urandom_range(1, 32)));
        msg_before = exp_msg;
        cycle(1'b1, rand_data(), mask_of_len(8), 1'b0, 1'b1);
        checks++;
        if (fill_level !== '0 || out_valid !== 1'b0 || overflow !== 1'b0 ||
            msg_count !== 16'(stat_exp(msg_before))) begin
            errors++;
            $display("FAIL flush: got fill=%0d valid=%0b ovf=%0b msg=%0d, expected fill=0 valid=0 ovf=0 msg=%0d",
                     fill_level, out_valid, overflow, msg_count, stat_exp(msg_before));
        end
        cycle(1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic test_stream();
        apply_reset();
        for (int i = 0; i < 40; i++) cycle(1'b1, rand_data(), mask_of_len($urandom_range(1, 32)), 1'b1, 1'b0);
        checks++;
        if (msg_count !== 16'(stat_exp(40)) || fill_level !== 4'd1) begin
            errors++;
            $display("FAIL stream: got msg=%0d fill=%0d, expected msg=%0d fill=1",
                     msg_count, fill_level, stat_exp(40));
        end
        push(rand_data(), mask_of_len(9));
        push(rand_data(), mask_of_len(3));
        #2;
        apply_reset();
        cycle(1'b0, '0, '0, 1'b1, 1'b0);
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        exp_msg     = 0;
        exp_drop    = 0;
        reset_n     = 1'b1;
        in_valid    = 1'b0;
        in_data     = '0;
        in_bytemask = '0;
        flush       = 1'b0;
        out_ready   = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_fill_overflow();
        test_full_push_pop();
        test_zero_mask();
        test_flush();
        test_stream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/msg_fifo_buffer.md
Name: msg_fifo_buffer

Overview:
- Downstream stage of the message extractor; absorbs its 256-bit message words (out_data / out_bytemask / out_valid) into a show-ahead FIFO.
- Attaches a byte length to each message and presents a valid/ready stream to the consumer (order book / decoder).
- The extractor has no backpressure input, so this block never stalls its input. It drops on full and flags the drop.

Parameters:
- DEPTH, 8, message entries; power of two, minimum 2.
- ADDR_W, 3, log2(DEPTH).
- DATA_W, 256, message data width.
- MASK_W, 32, byte-mask width (DATA_W/8).
- LEN_W, 6, byte-length width; holds 0..32.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  message word present; one message per cycle.
- in_data  in  DATA_W  message bytes, right-justified; last byte in [7:0].
- in_bytemask  in  MASK_W  contiguous ones from bit 0; one bit per valid byte.
- flush  in  1  synchronous FIFO clear.
- out_ready  in  1  consumer accepts head entry.
- out_valid  out  1  head entry valid.
- out_data  out  DATA_W  head data.
- out_bytemask  out  MASK_W  head mask.
- out_length  out  LEN_W  popcount of head mask.
- fill_level  out  ADDR_W+1  entries currently held, 0..DEPTH.
- overflow  out  1  one-cycle pulse on each dropped message.
- msg_count  out  16  accepted messages, saturating at 16'hFFFF.
- drop_count  out  16  dropped messages, saturating at 16'hFFFF.

Behaviour:
- Reset (asynchronous, reset_n low) clears:
  - pointers (ADDR_W+1 bits each, including a wrap bit);
  - out_valid=0, fill_level=0, overflow=0, msg_count=0, drop_count=0.
  - out_data / out_bytemask / out_length read 0 while empty.
- Memory contents are not reset.
- Write qualifier: in_valid & (in_bytemask != 0) & !flush.
  - Zero-mask words are ignored silently: not stored, not counted, no overflow.
- Write accepted when !full, or when full and a pop occurs the same cycle (out_valid & out_ready). The entry stored is {data, mask, length}.
- Length is computed at write time: popcount of in_bytemask, stored alongside the entry.
- Write qualifier true but not accepted:
  - message dropped;
  - overflow=1 on the following cycle only;
  - drop_count increments.
- Pop: out_valid & out_ready advances the read pointer.
- Show-ahead:
  - out_* driven combinationally from the head entry;
  - out_valid = !empty.
- Latency: a message written at edge N gives out_valid=1 after edge N, with that message on out_data.
- Full/empty: equal pointer index with differing wrap bit = full; equal pointers = empty.
  - fill_level = wr_ptr - rd_ptr, modulo 2^(ADDR_W+1).
- Simultaneous push and pop:
  - when empty: no pop is possible; the push lands and out_valid rises next cycle;
  - otherwise: both occur and fill_level is unchanged.
- Flush:
  - both pointers set to 0 on the next edge; out_valid=0 next cycle;
  - a concurrent input is discarded with no overflow;
  - counters are kept.
- Pointer wrap: ADDR_W+1 bit natural wrap; no special handling.
- out_ready while empty: no effect.
- Counters saturate; they never wrap.
- Reset mid-operation: all queued messages are lost; the output resumes empty.

Optional Feature:
- MSG_FIFO_STATS_EN defined: msg_count and drop_count are implemented as described.
- Not defined:
  - both counters are tied to 0 and their registers are removed;
  - overflow pulse and drop behaviour are unchanged.

Decomposition:
- Package msg_pkg holds:
  - MSG_DATA_W=256, MSG_MASK_W=32, MSG_LEN_W=6, CNT_W=16;
  - a popcount function for the mask.
- One sub-module, msg_len_calc: combinational in_bytemask -> length, reusable by other stages.
- The FIFO array and control stay in msg_fifo_buffer.

Test Plan:
- Reset, then a single write (data=256'h...A5, mask=32'h0000003F) with out_ready=0 -> next cycle out_valid=1, out_length=6, fill_level=1. Raise out_ready for one cycle -> out_valid=0, fill_level=0.
- Write 8 messages back-to-back, out_ready=0 -> fill_level=8. 9th write -> overflow pulses one cycle, drop_count=1, contents unchanged. Drain -> order preserved, lengths correct.
- Full FIFO, in_valid and out_ready high together -> write accepted, no overflow, fill_level stays 8, new entry emerges last.
- in_valid with in_bytemask=0 -> no write, no overflow, fill_level unchanged. Mask 32'hFFFFFFFF -> out_length=32.
- With 5 entries, assert flush together with in_valid -> next cycle fill_level=0, out_valid=0, overflow=0, msg_count unchanged.
- Continuous write+read for 40 cycles (pointer wrap) -> no loss, msg_count=40. Deassert reset_n mid-stream -> all outputs 0 immediately.
